// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Each granted transaction walks IDLE -> ACCESS -> RESP -> ACK. The RAM
// address, write data and write enable all come from registers, so the RAM
// sees stable inputs and write enable is high for exactly one cycle.
//
// Request handshake: a master raises req with we/addr/wdata valid and keeps
// req high until it sees its one-cycle ack. The fields are sampled only on
// the grant edge. Read data is valid in the ack cycle and is held until that
// master's next read completes.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  // Number of ACCESS cycles before mem_rdata is valid; legal range 1..15.
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] lat_cnt;
  logic       txn_we;   // direction of the transaction in flight
  logic       grant;
  logic       winner;

  // Round-robin choice; owner doubles as last_grant, so a tie goes to the
  // master that was not served most recently.
  always_comb begin
    grant  = m0_req | m1_req;
    winner = owner;
    if (m0_req && m1_req) winner = ~owner;
    else if (m0_req)      winner = 1'b0;
    else if (m1_req)      winner = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; arbitration only takes effect from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  if (lat_cnt == 4'd0) state_next = RESP;
      RESP:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status and completion outputs decoded from the state.
  always_comb begin
    busy      = (state != IDLE);
    m0_ack    = (state == ACK) && !owner;
    m1_ack    = (state == ACK) && owner;
    fsm_state = state;
  end

  // RAM-side registers: load on grant, drop write enable after one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      owner     <= 1'b1;
      lat_cnt   <= 4'd0;
      txn_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (grant) begin
            owner     <= winner;
            mem_addr  <= winner ? m1_addr  : m0_addr;
            mem_wdata <= winner ? m1_wdata : m0_wdata;
            mem_we    <= winner ? m1_we    : m0_we;
            txn_we    <= winner ? m1_we    : m0_we;
            lat_cnt   <= LAT_LOAD;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  // Read-data capture into the owning master's register at the end of RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == RESP && !txn_we) begin
      if (owner) m1_rdata <= mem_rdata;
      else       m0_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master round-robin arbiter that shares the single-port synchronous RAM between the CPU bus (master 0) and a second requester (master 1, e.g. a loader or DMA engine).
- Sits between the masters and the RAM instance. I/O decode stays outside this block.
- Each transaction is serialized through a small FSM.
- RAM write-enable and address are registered, so the RAM only ever sees stable, single-cycle writes.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LATENCY, 1, number of ACCESS cycles the RAM address is held before read data is valid. Legal range is 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_rdata  out  DW  master 0 read data (registered), valid while m0_ack=1
- m0_ack  out  1  master 0 one-cycle completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1
- mem_addr  out  AW  RAM address (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_rdata  in  DW  RAM read data, valid the cycle after the last ACCESS cycle
- busy  out  1  1 in any state other than IDLE
- owner  out  1  index of the master currently or most recently granted

Behaviour:
- Reset (async):
  - state=IDLE, all ack=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - m0_rdata=m1_rdata=0, last_grant=1, so master 0 wins the first tie; owner=1.
  - Reset asserted mid-transaction aborts it with no ack and no further mem_we.
- States are IDLE, ACCESS, RESP, ACK.
- IDLE:
  - Arbitration happens only in this state.
  - If only one req is high, grant that master.
  - If both are high, grant the master != last_grant.
  - On grant (clock edge):
    - Register the winner's addr, wdata and we into mem_addr, mem_wdata and mem_we.
    - Set owner and last_grant to the winner.
    - Load lat_cnt=RD_LATENCY-1 and go to ACCESS.
  - With no req, stay in IDLE with mem_we=0 and mem_addr holding its last value.
- ACCESS:
  - mem_addr and mem_wdata are held.
  - mem_we is high only in the first ACCESS cycle and cleared at the end of it.
  - Decrement lat_cnt each cycle; when lat_cnt=0, go to RESP.
- RESP:
  - For reads, capture mem_rdata into owner's rdata register at the end of the cycle.
  - For writes, the rdata register is unchanged.
  - Next state is ACK.
- ACK:
  - owner's ack=1 for exactly one cycle; the other master's ack=0.
  - No arbitration in this state, so a req still high while ack is seen is not re-granted.
  - Next state is IDLE.
- Latency: req sampled in cycle 0 (IDLE) gives ack in cycle RD_LATENCY+2. Default is cycle 3. Reads and writes have identical timing.
- Throughput: a master holding req continuously gets one grant per RD_LATENCY+3 cycles when alone. With both masters continuously requesting, grants alternate strictly 0,1,0,1,…
- Protocol violation: if a master drops req mid-transaction, the transaction still completes. The write is already issued, and ack still pulses.
- Requester fields are sampled only at the grant edge; later changes are ignored.
- rdata registers hold their value until the next read completes for that master.

Test Plan:
- Single read, RD_LATENCY=1: preload RAM[0x40]=0xDEADBEEF; m0 reads 0x40 -> m0_ack high in cycle 3 only; m0_rdata=0xDEADBEEF; m1_ack stays 0; mem_we never 1.
- Single write: m1 writes 0x1234_5678 to 0x80 -> mem_we=1 for exactly one cycle with mem_addr=0x80; m1_ack in cycle 3; a subsequent m0 read of 0x80 returns 0x12345678.
- Simultaneous requests after reset: m0 and m1 both read in the same cycle -> m0 acked in cycle 3 and m1 in cycle 7; owner sequence 0 then 1.
- Continuous contention: both masters hold req for 8 transactions each -> grant order alternates 0,1,0,1…; no master gets two consecutive grants; each ack is a single cycle.
- Reset mid-ACCESS: assert reset while a m0 write is in ACCESS -> mem_we=0 and busy=0 immediately; no ack; after release, m0 wins a tie with m1.
- RD_LATENCY=3: m0 read -> mem_addr stable for 3 ACCESS cycles; ack in cycle 5; correct data captured.
